// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART deserializer and the register block.
// Each entry holds {perr, ferr, data}. Pops are answered one cycle after the
// request, and a pop on an empty FIFO still answers (with zero data plus an
// underrun pulse), so a bus read never stalls.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_ferr,
  input  logic                     rx_perr,
  output logic                     rx_ready,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     ferr,
  output logic                     perr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     irq_set,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] THR_M1 = (AW+1)'(THRESH - 1);

  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              push_ok;
  logic              pop_ok;
  logic              irq_hit;
  logic [DATA_W+1:0] head;

  // Status flags and the accept decisions, all derived from registered pointers.
  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    level    = wptr - rptr;
    rx_ready = !full;
    push_ok  = rx_valid && !full;
    pop_ok   = rd_req && !empty;
    head     = mem[rptr[AW-1:0]];
    // A pop alongside the push leaves the level unchanged, so only a lone push
    // can cross THRESH-1 -> THRESH.
    irq_hit  = push_ok && !pop_ok && (level == THR_M1);
  end

  // Entry storage; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= {rx_perr, rx_ferr, rx_data};
    end
  end

  // Pointers, registered pop response and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      irq_set  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      underrun <= 1'b0;
      irq_set  <= irq_hit;
      overrun  <= rx_valid && full;
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr    <= rptr + 1'b1;
        rd_data <= head[DATA_W-1:0];
        ferr    <= head[DATA_W];
        perr    <= head[DATA_W+1];
      end else if (rd_req) begin
        rd_data  <= '0;
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed table, corner-case sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int THRESH = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_ready;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ferr;
  logic       perr;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       irq_set;
  logic       overrun;
  logic       underrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of {perr, ferr, data} entries.
  logic [9:0] q[$];
  logic [7:0] m_last;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_perr(rx_perr),
    .rx_ready(rx_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .ferr(ferr), .perr(perr),
    .empty(empty), .full(full), .level(level),
    .irq_set(irq_set), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare every output
  // against the model advanced by the same inputs.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic fe, input logic pe, input logic rq);
    int         pre;
    logic       e_rv, e_fe, e_pe, e_un, e_ov, e_irq;
    logic [9:0] ent;
    rst = r; rx_valid = v; rx_data = d; rx_ferr = fe; rx_perr = pe; rd_req = rq;
    @(posedge clk);
    #1;
    e_rv = 0; e_fe = 0; e_pe = 0; e_un = 0; e_ov = 0; e_irq = 0;
    if (r) begin
      q.delete();
      m_last = 8'h00;
    end else begin
      pre  = q.size();
      e_rv = rq;
      e_ov = v && (pre == DEPTH);
      if (rq) begin
        if (pre > 0) begin
          ent    = q.pop_front();
          m_last = ent[7:0];
          e_fe   = ent[8];
          e_pe   = ent[9];
        end else begin
          m_last = 8'h00;
          e_un   = 1;
        end
      end
      if (v && pre < DEPTH) q.push_back({pe, fe, d});
      e_irq = v && (pre < DEPTH) && (pre == THRESH - 1) && (q.size() == THRESH);
    end
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    chk("rd_data",  32'(rd_data),  32'(m_last));
    chk("ferr",     32'(ferr),     32'(e_fe));
    chk("perr",     32'(perr),     32'(e_pe));
    chk("level",    32'(level),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("rx_ready", 32'(rx_ready), 32'(q.size() != DEPTH));
    chk("irq_set",  32'(irq_set),  32'(e_irq));
    chk("overrun",  32'(overrun),  32'(e_ov));
    chk("underrun", 32'(underrun), 32'(e_un));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       rq;
    logic       erv;
    logic [7:0] ed;
    logic       ef;
    logic       ep;
    int         el;
  } vec_t;

  vec_t tv[7];

  initial begin
    int         maxlvl;
    logic [7:0] b;

    tv[0] = '{1, 8'h41, 0, 0, 0,  0, 8'h00, 0, 0, 1};
    tv[1] = '{1, 8'h42, 1, 0, 0,  0, 8'h00, 0, 0, 2};
    tv[2] = '{1, 8'h43, 0, 1, 0,  0, 8'h00, 0, 0, 3};
    tv[3] = '{0, 8'h00, 0, 0, 1,  1, 8'h41, 0, 0, 2};
    tv[4] = '{0, 8'h00, 0, 0, 1,  1, 8'h42, 1, 0, 1};
    tv[5] = '{0, 8'h00, 0, 0, 1,  1, 8'h43, 0, 1, 0};
    tv[6] = '{0, 8'h00, 0, 0, 0,  0, 8'h43, 0, 0, 0};

    m_last = 8'h00;

    // Reset state.
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    step(0, 0, 8'h00, 0, 0, 0);

    // Order and flags, table-driven.
    foreach (tv[i]) begin
      step(0, tv[i].v, tv[i].d, tv[i].fe, tv[i].pe, tv[i].rq);
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tv[i].erv));
      chk("tbl_rd_data",  32'(rd_data),  32'(tv[i].ed));
      chk("tbl_ferr",     32'(ferr),     32'(tv[i].ef));
      chk("tbl_perr",     32'(perr),     32'(tv[i].ep));
      chk("tbl_level",    32'(level),    32'(tv[i].el));
    end

    // Fill to full, then overrun with 0xAA, then drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_rx_ready", 32'(rx_ready), 32'd0);
    chk("fill_level", 32'(level), 32'd16);
    step(0, 1, 8'hAA, 0, 0, 0);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 0, 0, 1);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Underrun on empty.
    step(0, 0, 8'h00, 0, 0, 1);
    chk("unr_pulse", 32'(underrun), 32'd1);
    chk("unr_data", 32'(rd_data), 32'd0);

    // Push/pop pairs with incrementing data across pointer wrap.
    maxlvl = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'(8'h80 + i);
      step(0, 1, b, 0, 0, 0);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      step(0, 0, 8'h00, 0, 0, 1);
      chk("wrap_data", 32'(rd_data), 32'(b));
    end
    chk("wrap_maxlvl", 32'(maxlvl), 32'd1);

    // irq on push into empty; simultaneous push+pop at level 3.
    step(0, 1, 8'h11, 0, 0, 0);
    chk("irq_first", 32'(irq_set), 32'd1);
    step(0, 1, 8'h12, 0, 0, 0);
    chk("irq_nopulse", 32'(irq_set), 32'd0);
    step(0, 1, 8'h13, 0, 0, 0);
    step(0, 1, 8'h14, 1, 1, 1);
    chk("simul_level", 32'(level), 32'd3);
    chk("simul_irq", 32'(irq_set), 32'd0);
    chk("simul_data", 32'(rd_data), 32'h11);

    // Reset alongside a pop request: no response afterwards.
    step(1, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("rstpop_valid", 32'(rd_valid), 32'd0);
    chk("rstpop_level", 32'(level), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 99) < 45));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
